// File: rtl/gb_audio_pkg.sv
// Shared definitions for the Game Boy audio back-end: widths, FSM states and
// the sample attenuation rule.
package gb_audio_pkg;

  localparam int GB_AUDIO_W    = 16;
  localparam int I2S_SLOT_BITS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mute wins over the attenuation shift; the shift keeps the sign.
  function automatic logic [GB_AUDIO_W-1:0] attenuate(
    input logic [GB_AUDIO_W-1:0] sample,
    input logic [1:0]            shift,
    input logic                  silence
  );
    logic signed [GB_AUDIO_W-1:0] s;
    s = sample;
    return silence ? '0 : GB_AUDIO_W'(s >>> shift);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles o_bclk every BCLK_DIV clk cycles while enabled and
// flags the cycle in which a 1->0 toggle is about to happen.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             w_div_wrap;

  assign w_div_wrap = (r_div_cnt == DIV_W'(BCLK_DIV - 1));

  // Disabling clears the divider so every run starts with a rising edge first.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_bclk = r_bclk;
  assign o_fall = i_en & w_div_wrap & r_bclk;

endmodule

// File: rtl/gb_i2s_tx.sv
// Philips I2S transmitter for the Game Boy core's stereo samples: frame latch
// with mute/attenuation, slot sequencing and registered BCLK/LRCLK/SDATA.
module gb_i2s_tx
  import gb_audio_pkg::*;
#(
  parameter int BCLK_DIV  = 1,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int DATA_BITS = GB_AUDIO_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mute,
  input  logic [1:0]           vol,
  input  logic [DATA_BITS-1:0] left,
  input  logic [DATA_BITS-1:0] right,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 sample_tick,
  output logic                 busy
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = $clog2(DATA_BITS);

  state_t               r_state, w_state_next;
  logic                 w_run, w_fall, w_bclk;
  logic                 w_wrap, w_latch, w_stop;
  logic [CNT_W-1:0]     r_bit_cnt, w_pos;
  logic [DATA_BITS-1:0] r_shadow_l, r_shadow_r, w_word;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_lr, w_bit;
  logic                 r_lrclk, r_sdata, r_tick;

  assign w_run = (r_state == RUN);

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_run),
    .o_bclk (w_bclk),
    .o_fall (w_fall)
  );

  assign w_wrap = w_fall && (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  // NOTE: reset is sampled on the clock edge and all state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: defaulting every comb output first keeps these blocks latch-free.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (en) w_state_next = RUN;
      RUN:     if (w_wrap && !en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_latch = 1'b0;
    w_stop  = 1'b0;
    case (r_state)
      IDLE: w_latch = en;
      RUN: begin
        w_latch = w_wrap && en;
        w_stop  = w_wrap && !en;
      end
      default: ;
    endcase
  end

  // Slot decode for the current bit position; outputs register it one BCLK later.
  assign w_lr   = (r_bit_cnt >= CNT_W'(SLOT_BITS));
  assign w_pos  = w_lr ? (r_bit_cnt - CNT_W'(SLOT_BITS)) : r_bit_cnt;
  assign w_word = w_lr ? r_shadow_r : r_shadow_l;

  always_comb begin
    w_idx = '0;
    w_bit = 1'b0;
    if (w_pos >= CNT_W'(1) && w_pos <= CNT_W'(DATA_BITS)) begin
      w_idx = IDX_W'(DATA_BITS - int'(w_pos));
      w_bit = w_word[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_tick     <= 1'b0;
      r_shadow_l <= '0;
      r_shadow_r <= '0;
    end else begin
      r_tick <= w_latch;
      if (w_latch) begin
        r_shadow_l <= DATA_BITS'(attenuate(GB_AUDIO_W'(left),  vol, mute));
        r_shadow_r <= DATA_BITS'(attenuate(GB_AUDIO_W'(right), vol, mute));
      end
      if (!w_run || w_stop) begin
        r_bit_cnt <= '0;
        r_lrclk   <= 1'b0;
        r_sdata   <= 1'b0;
      end else if (w_fall) begin
        r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + 1'b1;
        r_lrclk   <= w_lr;
        r_sdata   <= w_bit;
      end
    end
  end

  assign i2s_bclk    = w_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_sdata   = r_sdata;
  assign sample_tick = r_tick;
  assign busy        = w_run;

endmodule

// File: tb/tb_gb_i2s_tx.sv
// Self-checking bench for gb_i2s_tx: an I2S receiver decodes the serial stream
// and compares each slot with the attenuated samples predicted at every latch.
module tb_gb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, en3, mute;
  logic [1:0]  vol;
  logic [15:0] left, right;
  logic        bclk, lrclk, sdata, tick, busy;
  logic        bclk3, lrclk3, sdata3, tick3, busy3;

  gb_i2s_tx u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mute(mute), .vol(vol),
    .left(left), .right(right),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .sample_tick(tick), .busy(busy)
  );

  gb_i2s_tx #(.BCLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mute(mute), .vol(vol),
    .left(left), .right(right),
    .i2s_bclk(bclk3), .i2s_lrclk(lrclk3), .i2s_sdata(sdata3),
    .sample_tick(tick3), .busy(busy3)
  );

  typedef struct { logic [15:0] l; logic [15:0] r; } exp_t;
  typedef struct { logic lr; logic [15:0] w; } word_t;
  typedef struct { logic prev_bclk; logic prev_lr; int pos; logic [15:0] sh; } dec_t;

  exp_t  exp_q[$], exp3_q[$];
  word_t dec_q[$], dec3_q[$];
  dec_t  ds  = '{1'b0, 1'b0, -2, 16'h0};
  dec_t  ds3 = '{1'b0, 1'b0, -2, 16'h0};

  int n_checks = 0, n_err = 0;
  int pad_err = 0, pad_err3 = 0, tick_cnt = 0;
  bit rand_left = 1'b0;

  logic [15:0] snap_l, snap_r;
  logic [1:0]  snap_v;
  logic        snap_m;

  // Sample value = floor(x / 2^vol), or zero when muted.
  function automatic logic [15:0] model(input logic [15:0] s, input logic [1:0] v, input logic m);
    int x, d, q;
    x = int'($signed(s));
    d = 1 << v;
    if (x >= 0) q = x / d;
    else        q = -((-x + d - 1) / d);
    return m ? 16'h0 : 16'(q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // I2S receiver: bits taken on BCLK rising edges, slot restarts on each LRCLK change;
  // after a start the left MSB follows the second falling event.
  task automatic dec_step(input logic b, input logic lr, input logic sd, input logic run,
                          input dec_t si, output dec_t so,
                          output logic got, output word_t wd, output logic perr);
    so   = si;
    got  = 1'b0;
    perr = 1'b0;
    wd   = '{lr, 16'h0};
    if (!run) begin
      so.pos     = -2;
      so.prev_lr = 1'b0;
    end else if (b && !si.prev_bclk) begin
      if (lr != si.prev_lr) so.pos = 0;
      else                  so.pos = si.pos + 1;
      so.prev_lr = lr;
      if (so.pos >= 1 && so.pos <= 16) begin
        so.sh = {si.sh[14:0], sd};
        if (so.pos == 16) begin
          got = 1'b1;
          wd  = '{lr, so.sh};
        end
      end else if (sd !== 1'b0) begin
        perr = 1'b1;
      end
    end
    so.prev_bclk = b;
  endtask

  always @(posedge clk) begin
    snap_l <= left;
    snap_r <= right;
    snap_v <= vol;
    snap_m <= mute;
  end

  always @(negedge clk) begin
    logic  g, pe;
    word_t w;
    if (tick === 1'b1) begin
      exp_q.push_back('{model(snap_l, snap_v, snap_m), model(snap_r, snap_v, snap_m)});
      tick_cnt++;
    end
    if (tick3 === 1'b1)
      exp3_q.push_back('{model(snap_l, snap_v, snap_m), model(snap_r, snap_v, snap_m)});
    dec_step(bclk, lrclk, sdata, busy, ds, ds, g, w, pe);
    if (g) dec_q.push_back(w);
    if (pe) pad_err++;
    dec_step(bclk3, lrclk3, sdata3, busy3, ds3, ds3, g, w, pe);
    if (g) dec3_q.push_back(w);
    if (pe) pad_err3++;
  end

  task automatic tick1();
    @(negedge clk);
    if (rand_left) left = 16'($urandom);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick1();
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return tick;
      1:       return bclk;
      2:       return lrclk;
      3:       return busy;
      4:       return tick3;
      5:       return bclk3;
      default: return busy3;
    endcase
  endfunction

  // Cycles until the chosen edge, or -1 when the budget runs out.
  task automatic wait_edge(input int which, input bit rising, input int max, output int c);
    logic p, cur;
    c = -1;
    p = get_sig(which);
    for (int i = 1; i <= max; i++) begin
      tick1();
      cur = get_sig(which);
      if (rising ? (cur && !p) : (!cur && p)) begin
        c = i;
        break;
      end
      p = cur;
    end
  endtask

  task automatic drain(input bit sel, input string tag);
    exp_t  e;
    word_t a, b;
    int    pairs = 0;
    while (1) begin
      if (sel) begin
        if (exp3_q.size() == 0 || dec3_q.size() < 2) break;
        e = exp3_q.pop_front(); a = dec3_q.pop_front(); b = dec3_q.pop_front();
      end else begin
        if (exp_q.size() == 0 || dec_q.size() < 2) break;
        e = exp_q.pop_front(); a = dec_q.pop_front(); b = dec_q.pop_front();
      end
      check({tag, "_left"},  {15'd0, a.lr, a.w}, {15'd0, 1'b0, e.l});
      check({tag, "_right"}, {15'd0, b.lr, b.w}, {15'd0, 1'b1, e.r});
      pairs++;
    end
    check({tag, "_pairs"}, 32'(pairs > 0), 32'd1);
  endtask

  initial begin
    int c, c2, tc;
    rst_n = 1'b0; en = 1'b0; en3 = 1'b0; mute = 1'b0; vol = 2'd0;
    left = 16'h0; right = 16'h0;
    wait_cyc(3);
    check("rst_outputs",  {27'd0, bclk, lrclk, sdata, tick, busy}, 32'd0);
    check("rst_outputs3", {27'd0, bclk3, lrclk3, sdata3, tick3, busy3}, 32'd0);

    // Default rates and first decoded frames.
    rst_n = 1'b1; left = 16'h8001; right = 16'h7FFE;
    tick1();
    en = 1'b1;
    wait_edge(0, 1'b1, 10, c);   check("start_tick", c, 1);
    check("busy_run", {31'd0, busy}, 32'd1);
    wait_edge(1, 1'b1, 10, c);
    wait_edge(1, 1'b1, 10, c);   check("bclk_period", c, 2);
    wait_edge(2, 1'b1, 300, c);
    wait_edge(2, 1'b1, 300, c);  check("lrclk_period", c, 128);
    wait_edge(0, 1'b1, 300, c);
    wait_edge(0, 1'b1, 300, c);  check("tick_period", c, 128);
    wait_cyc(10);
    drain(1'b0, "base");
    check("pad_bits", pad_err, 0);

    vol = 2'd2; left = 16'hFFFC; right = 16'h0010;
    wait_cyc(3 * 128);
    drain(1'b0, "vol2");
    vol = 2'd3; left = 16'h8000;
    wait_cyc(2 * 128);
    drain(1'b0, "vol3");

    vol = 2'd0; mute = 1'b1; left = 16'h1234; right = 16'($urandom);
    wait_cyc(2 * 128);
    drain(1'b0, "mute");
    mute = 1'b0;
    wait_cyc(2 * 128);
    drain(1'b0, "unmute");

    for (int i = 0; i < 8; i++) begin
      left = 16'($urandom); right = 16'($urandom);
      vol = 2'($urandom); mute = ($urandom_range(0, 3) == 0);
      wait_cyc($urandom_range(30, 150));
    end
    wait_cyc(140);
    drain(1'b0, "random");
    mute = 1'b0; vol = 2'd0;

    // en glitch inside a frame is ignored.
    wait_edge(0, 1'b1, 300, c);
    wait_cyc(20); en = 1'b0; wait_cyc(10); en = 1'b1;
    wait_edge(0, 1'b1, 300, c);  check("glitch_tick", 30 + c, 128);
    check("glitch_busy", {31'd0, busy}, 32'd1);

    // Stop requested at bit 40: frame completes, then idle.
    left = 16'h8001; right = 16'h7FFE;
    wait_edge(0, 1'b1, 300, c);
    wait_cyc(80); en = 1'b0;
    wait_edge(3, 1'b0, 300, c);  check("stop_at_frame_end", 80 + c, 128);
    check("idle_outputs", {29'd0, bclk, lrclk, sdata}, 32'd0);
    tc = tick_cnt;
    wait_cyc(50);
    check("idle_no_tick", tick_cnt, tc);
    check("idle_hold", {28'd0, bclk, lrclk, sdata, busy}, 32'd0);
    drain(1'b0, "stop");

    // Restart: pad after first falling event, MSB after the second.
    en = 1'b1;
    wait_edge(0, 1'b1, 10, c);   check("restart_tick", c, 1);
    check("restart_sdata0", {31'd0, sdata}, 32'd0);
    wait_edge(1, 1'b0, 10, c);   check("restart_fall1", c, 2);
    check("restart_pad", {31'd0, sdata}, 32'd0);
    wait_edge(1, 1'b0, 10, c);   check("restart_fall2", c, 2);
    check("restart_msb", {31'd0, sdata}, 32'd1);
    wait_cyc(2 * 128);
    drain(1'b0, "restart");

    // Reset at bit 20 aborts the frame; release restarts from bit 0.
    wait_edge(0, 1'b1, 300, c);
    wait_cyc(40);
    rst_n = 1'b0;
    tick1();
    check("midreset_outputs", {27'd0, bclk, lrclk, sdata, tick, busy}, 32'd0);
    exp_q.delete(); dec_q.delete();
    left = 16'($urandom); right = 16'($urandom);
    rst_n = 1'b1;
    tick1();
    check("post_reset_tick", {31'd0, tick}, 32'd1);
    wait_edge(0, 1'b1, 300, c);  check("post_reset_period", c, 128);
    wait_cyc(130);
    drain(1'b0, "post_reset");
    check("pad_bits_all", pad_err, 0);

    en = 1'b0;
    wait_edge(3, 1'b0, 300, c);  check("final_stop", 32'(c > 0), 32'd1);

    // Divider of 3 with left changing every cycle.
    rand_left = 1'b1;
    en3 = 1'b1;
    wait_edge(4, 1'b1, 10, c);   check("div3_start_tick", c, 1);
    wait_edge(5, 1'b1, 20, c);
    wait_edge(5, 1'b1, 20, c);   check("div3_bclk_period", c, 6);
    wait_edge(4, 1'b1, 800, c);
    wait_edge(4, 1'b1, 800, c2); check("div3_tick_period", c2, 384);
    wait_cyc(400);
    rand_left = 1'b0;
    wait_cyc(400);
    drain(1'b1, "div3");
    check("div3_pad_bits", pad_err3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
